// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared state encoding and line levels for the parallel-to-serial read side
package p2s_pkg;

    // Binary-encoded serializer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_serializer_bit_timer.sv
// rtl/fifo_serializer_bit_timer.sv - per-bit tick counter with end-of-bit strobe
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    force the counter back to 0 on the next edge
//   bit_end_o  high in the last cycle of the current serial bit
module bit_timer #(
    parameter int unsigned clks_per_bit = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bit_end_o
);

    logic [7:0] tick_q;
    logic [7:0] tick_d;

    assign bit_end_o = (tick_q == 8'(clks_per_bit - 1));

    // Wrap at the end of every bit so consecutive bits inside DATA restart at 0
    always_comb begin
        tick_d = tick_q + 8'd1;
        if (clear_i || bit_end_o) begin
            tick_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_q <= 8'd0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - pops FIFO words and sends them as start/data/parity/stop frames
//
// Ports:
//   clk_out     serializer clock, all state on its rising edge
//   rst         asynchronous active-low reset
//   rdata       FIFO read data, valid the cycle after remove
//   empty       FIFO empty flag
//   flush       synchronous abort back to IDLE
//   remove      one-cycle pop request per word
//   serial_out  serial line, idles high
//   busy        high from the pop through the last stop-bit cycle
//   word_done   one-cycle pulse in the final stop-bit cycle
module fifo_serializer
    import p2s_pkg::*;
#(
    parameter int unsigned width        = 8,
    parameter int unsigned clks_per_bit = 1,
    parameter bit          parity_en    = 1'b0
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic [width-1:0] rdata,
    input  logic             empty,
    input  logic             flush,
    output logic             remove,
    output logic             serial_out,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = (width > 1) ? $clog2(width) : 1;

    state_e           state_q, state_d;
    logic [width-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             bit_end;
    logic             timed_state;

    // Only the line-driving states consume clks_per_bit cycles per bit
    assign timed_state = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);

    bit_timer #(
        .clks_per_bit(clks_per_bit)
    ) u_bit_timer (
        .clk_i    (clk_out),
        .rst_ni   (rst),
        .clear_i  ((state_d != state_q) || !timed_state),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                shift_d   = rdata;
                parity_d  = ^rdata;
                bit_cnt_d = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CW'(width - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chain straight into the next pop so frames go back-to-back
                if (bit_end) begin
                    state_d = empty ? ST_IDLE : ST_POP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort wins over any pop decision made above
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs decode only registered state and the tick counter
    always_comb begin
        serial_out = LINE_IDLE;
        remove     = 1'b0;
        busy       = (state_q != ST_IDLE);
        word_done  = 1'b0;
        case (state_q)
            ST_POP:    remove     = 1'b1;
            ST_START:  serial_out = START_BIT;
            ST_DATA:   serial_out = shift_q[0];
            ST_PARITY: serial_out = parity_q;
            ST_STOP: begin
                serial_out = STOP_BIT;
                word_done  = bit_end;
            end
            default: serial_out = LINE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - self-checking bench for fifo_serializer
module tb_fifo_serializer;

    typedef struct packed {
        logic fl;
        logic rm;
        logic bsy;
        logic ser;
        logic wd;
    } vec_t;

    logic       clk_out = 1'b0;
    logic       rst     = 1'b0;
    logic [2:0] emp     = 3'b111;
    logic [2:0] fl      = 3'b000;
    logic [2:0] rm, ser, bsy, wd;
    logic [7:0] rd [3]  = '{8'h00, 8'h00, 8'h00};
    logic [2:0] wr_en   = 3'b000;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] fq0 [$];
    logic [7:0] fq1 [$];
    logic [7:0] fq2 [$];
    logic [7:0] eq0 [$];
    logic [7:0] eq1 [$];
    logic [7:0] eq2 [$];
    vec_t       tbl [$];

    logic [127:0] hist [3];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bad_pop  = 0;
    int rm_cnt [3] = '{0, 0, 0};
    int wd_cnt [3] = '{0, 0, 0};
    int cpb_of [3] = '{1, 1, 4};
    bit par_of [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk_out = ~clk_out;

    fifo_serializer #(.width(8), .clks_per_bit(1), .parity_en(1'b0)) u_a (
        .clk_out(clk_out), .rst(rst), .rdata(rd[0]), .empty(emp[0]), .flush(fl[0]),
        .remove(rm[0]), .serial_out(ser[0]), .busy(bsy[0]), .word_done(wd[0]));
    fifo_serializer #(.width(8), .clks_per_bit(1), .parity_en(1'b1)) u_b (
        .clk_out(clk_out), .rst(rst), .rdata(rd[1]), .empty(emp[1]), .flush(fl[1]),
        .remove(rm[1]), .serial_out(ser[1]), .busy(bsy[1]), .word_done(wd[1]));
    fifo_serializer #(.width(8), .clks_per_bit(4), .parity_en(1'b0)) u_c (
        .clk_out(clk_out), .rst(rst), .rdata(rd[2]), .empty(emp[2]), .flush(fl[2]),
        .remove(rm[2]), .serial_out(ser[2]), .busy(bsy[2]), .word_done(wd[2]));

    // Synchronous FIFO model: data appears the cycle after remove
    always @(posedge clk_out) begin
        if (wr_en[0]) fq0.push_back(wr_data);
        if (wr_en[1]) fq1.push_back(wr_data);
        if (wr_en[2]) fq2.push_back(wr_data);
        if (rm[0]) begin
            if (fq0.size() == 0) bad_pop++; else rd[0] <= fq0.pop_front();
        end
        if (rm[1]) begin
            if (fq1.size() == 0) bad_pop++; else rd[1] <= fq1.pop_front();
        end
        if (rm[2]) begin
            if (fq2.size() == 0) bad_pop++; else rd[2] <= fq2.pop_front();
        end
        emp[0] <= (fq0.size() == 0);
        emp[1] <= (fq1.size() == 0);
        emp[2] <= (fq2.size() == 0);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] frame_wave(input logic [7:0] w, input int cpb, input bit par);
        logic [127:0] v;
        logic b;
        int nb;
        v  = '0;
        nb = par ? 11 : 10;
        for (int k = 0; k < nb; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= 8) b = w[k-1];
            else if (par && k == 9) b = ^w;
            else b = 1'b1;
            for (int c = 0; c < cpb; c++) v = {v[126:0], b};
        end
        return v;
    endfunction

    function automatic logic [127:0] frame_mask(input int cpb, input bit par);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < (par ? 11 : 10) * cpb; i++) m[i] = 1'b1;
        return m;
    endfunction

    // One clock: sample at the falling edge, then scoreboard any finished frame
    task automatic tick();
        logic [7:0] w;
        bit have;
        @(negedge clk_out);
        wr_en = 3'b000;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            hist[i] = {hist[i][126:0], ser[i]};
            if (rm[i]) rm_cnt[i]++;
            if (wd[i]) begin
                wd_cnt[i]++;
                have = 1'b0;
                w    = 8'h00;
                case (i)
                    0: if (eq0.size() != 0) begin w = eq0.pop_front(); have = 1'b1; end
                    1: if (eq1.size() != 0) begin w = eq1.pop_front(); have = 1'b1; end
                    default: if (eq2.size() != 0) begin w = eq2.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word_done inst %0d: got word_done=1 required no pending frame", i);
                end else begin
                    check($sformatf("frame_inst%0d_%02h", i, w),
                          hist[i] & frame_mask(cpb_of[i], par_of[i]),
                          frame_wave(w, cpb_of[i], par_of[i]));
                end
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit expect_done);
        wr_data  = d;
        wr_en[i] = 1'b1;
        if (expect_done) begin
            case (i)
                0: eq0.push_back(d);
                1: eq1.push_back(d);
                default: eq2.push_back(d);
            endcase
        end
    endtask

    task automatic wait_wd(input int i, input int max, output int at);
        int n;
        at = -1;
        n  = 0;
        while (at < 0 && n < max) begin
            tick();
            if (wd[i]) at = cyc;
            n++;
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_word_done inst %0d: got timeout after %0d cycles required word_done", i, max);
        end
    endtask

    function automatic vec_t row(input logic f, input logic r, input logic b, input logic s, input logic d);
        vec_t v;
        v.fl = f; v.rm = r; v.bsy = b; v.ser = s; v.wd = d;
        return v;
    endfunction

    // Expected cycle-by-cycle outputs of a cpb=1, no-parity frame on instance 0
    task automatic build_frame(input logic [7:0] w, input int flush_at, input int n_rows);
        logic f;
        tbl.delete();
        for (int c = 0; c < n_rows; c++) begin
            f = (c == flush_at);
            if (c > flush_at) tbl.push_back(row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            else if (c == 1) tbl.push_back(row(f, 1'b1, 1'b1, 1'b1, 1'b0));
            else if (c == 2) tbl.push_back(row(f, 1'b0, 1'b1, 1'b1, 1'b0));
            else if (c == 3) tbl.push_back(row(f, 1'b0, 1'b1, 1'b0, 1'b0));
            else if (c >= 4 && c <= 11) tbl.push_back(row(f, 1'b0, 1'b1, w[c-4], 1'b0));
            else if (c == 12) tbl.push_back(row(f, 1'b0, 1'b1, 1'b1, 1'b1));
            else tbl.push_back(row(f, 1'b0, 1'b0, 1'b1, 1'b0));
        end
    endtask

    task automatic run_table(input string name);
        for (int c = 0; c < tbl.size(); c++) begin
            tick();
            check($sformatf("%s[%0d]", name, c), {rm[0], bsy[0], ser[0], wd[0]},
                  {tbl[c].rm, tbl[c].bsy, tbl[c].ser, tbl[c].wd});
            fl[0] = tbl[c].fl;
        end
        fl[0] = 1'b0;
    endtask

    initial begin
        int at1, at2, r0, d0;
        for (int i = 0; i < 3; i++) hist[i] = '0;

        rst = 1'b0;
        repeat (3) tick();
        check("reset_low", {rm, bsy, wd, ser}, 12'b000_000_000_111);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("reset_idle", {rm, bsy, wd, ser}, 12'b000_000_000_111);
        end

        build_frame(8'hA5, 99, 14);
        push(0, 8'hA5, 1'b1);
        run_table("frame_a5");

        r0 = rm_cnt[0];
        d0 = wd_cnt[0];
        build_frame(8'hFF, 7, 11);
        push(0, 8'hFF, 1'b0);
        run_table("flush_ff");
        check("flush_remove_count", rm_cnt[0] - r0, 1);
        check("flush_no_word_done", wd_cnt[0] - d0, 0);
        push(0, 8'h01, 1'b1);
        wait_wd(0, 30, at1);

        push(1, 8'hA5, 1'b1);
        tick();
        push(1, 8'h07, 1'b1);
        wait_wd(1, 40, at1);
        wait_wd(1, 40, at2);
        check("parity_spacing", at2 - at1, 13);

        push(2, 8'h3C, 1'b1);
        tick();
        push(2, 8'hC3, 1'b1);
        wait_wd(2, 100, at1);
        tick();
        check("b2b_remove", {rm[2], ser[2]}, 2'b11);
        tick();
        check("b2b_wait_high", {rm[2], ser[2]}, 2'b01);
        tick();
        check("b2b_start", ser[2], 1'b0);
        wait_wd(2, 100, at2);
        check("b2b_spacing", at2 - at1, 42);
        repeat (3) tick();

        push(2, 8'h5A, 1'b0);
        tick();
        push(2, 8'h96, 1'b1);
        repeat (40) tick();
        check("mid_stop", {rm[2], bsy[2], ser[2], wd[2]}, 4'b0110);
        rst = 1'b0;
        #1;
        check("reset_async", {rm[2], bsy[2], ser[2], wd[2]}, 4'b0010);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("pop_after_reset", {rm[2], bsy[2]}, 2'b11);
        wait_wd(2, 100, at1);
        repeat (3) tick();

        check("no_pop_while_empty", bad_pop, 0);
        check("scoreboard_drained", eq0.size() + eq1.size() + eq2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
Read-side consumer of the asynchronous FIFO in the parallel-to-serial interface, running entirely in the output clock domain.
- Pops one word at a time from the FIFO read port using `remove`/`empty`/`rdata`.
- Transmits each word on a single line as a frame: start bit, data bits LSB first, optional even parity, stop bit.
- Supports back-to-back frames and a synchronous flush abort.

Parameters:
- width, 8: FIFO data word width, equal to the number of data bits per frame.
- clks_per_bit, 1: `clk_out` cycles per serial bit; legal range 1..255.
- parity_en, 0: 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
- clk_out  input  1  serializer/read-domain clock; every register is clocked on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdata  input  width  FIFO read data; valid the cycle after `remove` is high.
- empty  input  1  FIFO empty flag, synchronous to `clk_out`.
- flush  input  1  synchronous abort, active-high.
- remove  output  1  FIFO pop request; a one-cycle pulse per word.
- serial_out  output  1  serial line; idles high.
- busy  output  1  high from the pop through the last stop-bit cycle.
- word_done  output  1  one-cycle pulse in the final stop-bit cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, serial_out=1, remove=0, busy=0, word_done=0, shift register=0, bit and tick counters=0.
- All outputs are registered (Moore): each output's value is defined by the current state and the counters.
- States: IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- IDLE: serial_out=1, busy=0. If !empty && !flush, go to POP; otherwise stay in IDLE.
- POP: lasts 1 cycle; remove=1, busy=1. Always goes to WAIT.
- WAIT: lasts 1 cycle; remove=0. Captures `rdata` into the shift register at the end of the cycle and computes parity as XOR of the captured word. Goes to START.
- START: serial_out=0 for clks_per_bit cycles, then DATA.
- DATA: serial_out=shift[0] for clks_per_bit cycles per bit. Shift right after each bit; bit_cnt counts 0..width-1. After bit width-1, go to PARITY if parity_en, else STOP.
- PARITY: serial_out=parity for clks_per_bit cycles, then STOP.
- STOP: serial_out=1 for clks_per_bit cycles. word_done=1 only in the last cycle of STOP. Exit:
  - to POP if !empty && !flush, with no IDLE cycle between frames;
  - otherwise to IDLE.
- Tick counter: counts 0..clks_per_bit-1 and resets on every state change. With clks_per_bit=1 every bit lasts exactly 1 cycle.
- Frame latency, clks_per_bit=1, parity off: POP cycle is cycle 1; START is cycle 3; data bits are cycles 4..11; STOP/word_done is cycle 12.
- Back-to-back: the line stays high for 2 cycles (POP and WAIT) between consecutive stop bits and start bits.
- flush: next state is IDLE from any state; serial_out=1, remove=0, busy=0, word_done=0.
  - A word already popped is discarded and never retransmitted.
  - flush has priority over a pop request in the same cycle.
- empty is sampled only in IDLE and in the last STOP cycle. A change of empty at any other time has no effect.
- remove is never asserted while empty=1. There is exactly one remove pulse per transmitted or aborted word.
- Reset mid-frame: serial_out returns to 1 immediately (asynchronously); the frame is lost.

Decomposition:
- Shared package p2s_pkg holds:
  - the state enum (3-bit, binary encoded);
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One natural sub-module: bit_timer (tick counter plus end-of-bit strobe), parameterised by clks_per_bit.

Test Plan:
- Reset with empty=1 -> serial_out=1, remove=0, busy=0 for 20 cycles; no state change.
- One word 0xA5, clks_per_bit=1, parity off -> remove pulse in cycle 1. serial_out sequence from cycle 3: 0,1,0,1,0,0,1,0,1,1. word_done in cycle 12.
- parity_en=1, words 0xA5 then 0x07 -> parity bit 0 for 0xA5 and 1 for 0x07. Frames are 11 bits each.
- Two queued words 0x3C,0xC3, clks_per_bit=4 -> second remove in the cycle right after the first STOP ends. Exactly 2 high cycles between the first stop bit and the second start bit; each bit lasts 4 cycles.
- flush asserted during DATA bit 3 of 0xFF -> next cycle state IDLE, serial_out=1, busy=0. No word_done and no extra remove. A following word 0x01 transmits cleanly.
- rst deasserted (low) mid-STOP, then released with empty=0 -> outputs return to reset values immediately; a new pop occurs 1 cycle after reset release.
